sd_dma_master: RTL
==================

# sd_dma_master

Bus initiator for the SD host DMA path: fetches bytes from system memory over the single-outstanding byte bus (bus_rd/bus_wr/bus_ready/bus_rdata_ready) toward the card-TX datapath, and stores bytes from the card-RX datapath back to memory. It sits between the SDIO data engine's byte streams and the `dma_serv`-style memory responder. It issues one transaction at a time and supports circular buffers through an address wrap length.

## Interface
- ADDR_W, 17, bus byte-address width
- LEN_W, 16, width of transfer and wrap lengths
- TIMEOUT, 255, maximum cycles to wait for a transaction to complete before flagging an error
- bus_clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_*; ignored while busy=1
- cfg_dir  in  1  0 = memory read (bus→dout), 1 = memory write (din→bus)
- cfg_addr  in  ADDR_W  start byte address
- cfg_len  in  LEN_W  bytes to move
- cfg_wrap  in  LEN_W  offset wrap length; 0 = linear addressing
- abort  in  1  stop the job after the current bus transaction
- dout / dout_valid / dout_ready  out/out/in  8/1/1  read-data stream (valid/ready)
- din / din_valid / din_ready  in/in/out  8/1/1  write-data stream (valid/ready)
- busy  out  1  job active
- done  out  1  one-cycle pulse at normal completion
- err  out  1  sticky timeout flag; cleared by the next accepted start
- bus_rd, bus_wr  out  1  one-cycle request pulses
- bus_addr  out  ADDR_W  held stable from the request until completion
- bus_wdata  out  8  held stable from the request until completion
- bus_ready  in  1  responder idle
- bus_rdata_ready  in  1  bus_rdata valid in this cycle
- bus_rdata  in  8  read data

## Operation
- States: IDLE, ISSUE, ACK, WAIT, DRAIN.
- IDLE: an accepted start latches the config and clears offset, count, and err.
  - cfg_len=0: done pulses in the next cycle; no bus traffic.
  - Otherwise the FSM enters ISSUE.
- ISSUE: a request is issued when bus_ready=1 and one of the following holds:
  - cfg_dir=0: the read hold register is empty.
  - cfg_dir=1: din_valid=1. din is then accepted (din_ready=1 for that cycle only) and copied to bus_wdata.
  - The request pulses bus_rd or bus_wr for exactly one cycle, and the FSM moves to ACK.
- ACK: one cycle. bus_ready is ignored here because the responder deasserts it one cycle after the request. Next state is WAIT.
- WAIT, read: on bus_rdata_ready, capture bus_rdata into the hold register.
- WAIT, write: complete on bus_ready=1.
- On completion: advance offset, increment count, then:
  - go to DRAIN if count reaches cfg_len or abort is pending;
  - otherwise go to ISSUE.
- Address rule: bus_addr = (cfg_addr + offset) mod 2^ADDR_W.
  - offset increments after each completed transaction.
  - offset returns to 0 when cfg_wrap≠0 and offset = cfg_wrap−1.
- Read hold register: one entry, driving dout/dout_valid. It is emptied on dout_valid & dout_ready.
- DRAIN: wait until the hold register is empty, then go to IDLE.
  - done pulses only if the job was not aborted.
  - An aborted job ends with busy=0 and neither done nor err.
- abort in ISSUE (no request outstanding): go to IDLE directly; the hold register is still drained.
- abort in ACK/WAIT: the outstanding transaction completes normally first.
- Timeout: a counter runs in ACK/WAIT and clears on each new request. At TIMEOUT it sets err and the FSM returns to IDLE with no done pulse.

## Timing
- Reset values: bus_rd=bus_wr=0, bus_addr=0, bus_wdata=0, dout=0, dout_valid=0, din_ready=0, busy=0, done=0, err=0; FSM in IDLE.
- busy rises in the cycle after an accepted start. It falls in the same cycle as done (or the abort/timeout exit).
- Request at cycle t; responder with a 6-cycle delay: bus_rdata_ready and bus_ready are high at t+7. Data is captured at t+7, and dout_valid is high from t+8.
- Back-to-back throughput is 8 cycles per byte: the next request goes out at t+8 when hold space or din is available.
- Reset mid-job: immediate return to IDLE; no pulses are generated afterward.

## Structure
- Package sd_dma_pkg: FSM state enum, ADDR_W/LEN_W defaults, DIR_RD/DIR_WR constants.
- Sub-module sd_dma_hold: the one-entry read holding register with valid/ready; everything else is in sd_dma_master.

## Test plan
- Read, cfg_addr=0x00100, len=4, wrap=0, dout_ready=1 → bus_addr 0x100..0x103; dout = memory contents in order; done after the 4th byte is consumed; 4 bus_rd pulses, each exactly 1 cycle.
- Read, cfg_addr=0x00200, len=6, wrap=4 → addresses 0x200,201,202,203,200,201.
- Write, len=3, din_valid gapped with 10 idle cycles → exactly 3 bus_wr pulses; each bus_wdata equals the accepted din; bus_addr stable through each WAIT; done once.
- Read with dout_ready=0 for 20 cycles → no new bus_rd while the hold register is full; no data loss; correct order.
- Abort asserted in WAIT of byte 2 of 5 → that transaction completes; no further requests; busy falls; done=0, err=0.
- Responder never returns bus_ready/bus_rdata_ready, TIMEOUT=255 → err=1 at 255 cycles after ACK; busy=0; err cleared by the next start; cfg_addr=0x1FFFF with len=2 → second address is 0x00000.

Source files
------------

// File: rtl/sd_dma_pkg.sv
// Shared types and constants for the SD host DMA bus initiator.
// Holds the FSM state encoding, default widths and the transfer-direction codes.
package sd_dma_pkg;

   localparam int DEF_ADDR_W = 17;
   localparam int DEF_LEN_W  = 16;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_ACK,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   // Offset step for circular buffers; wrap == 0 means linear addressing.
   function automatic logic [31:0] wrap_inc(input logic [31:0] off, input logic [31:0] wrap);
      return (wrap != 32'd0 && off == wrap - 32'd1) ? 32'd0 : off + 32'd1;
   endfunction

endpackage

// File: rtl/sd_dma_hold.sv
// One-entry holding register for bytes fetched from memory.
// Presents the byte on a valid/ready stream until the consumer takes it.
module sd_dma_hold (
   input  logic       bus_clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_data,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready
);

   always_ff @(posedge bus_clk) begin
      // NOTE: the data byte is reset as well, so dout reads 0 until the first fetch.
      if (rst) begin
         dout       <= 8'h00;
         dout_valid <= 1'b0;
      end else if (load) begin
         dout       <= load_data;
         dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sd_dma_master.sv
// Single-outstanding byte-bus initiator moving bytes between memory and the
// SDIO data streams, with circular-buffer addressing and a transaction timeout.
module sd_dma_master
   import sd_dma_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LEN_W   = DEF_LEN_W,
   parameter int TIMEOUT = 255
) (
   input  logic              bus_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cfg_dir,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [LEN_W-1:0]  cfg_wrap,
   input  logic              abort,
   output logic [7:0]        dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   input  logic [7:0]        din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              bus_rd,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   input  logic              bus_ready,
   input  logic              bus_rdata_ready,
   input  logic [7:0]        bus_rdata
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state, state_nx;
   logic              dir_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q, wrap_q, offset, count;
   logic [TW-1:0]     tcnt;
   logic              abort_q;
   logic [7:0]        wdata_q;
   logic              accept, issue, complete, abort_now, last, tmo, hold_space, hold_load;

   assign busy       = (state != ST_IDLE);
   assign accept     = start && (state == ST_IDLE);
   assign abort_now  = abort || abort_q;
   // A byte leaving the hold register this cycle frees it for the next fetch.
   assign hold_space = !dout_valid || dout_ready;
   assign last       = ((count + LEN_W'(1)) == len_q);
   assign complete   = (state == ST_WAIT) && ((dir_q == DIR_WR) ? bus_ready : bus_rdata_ready);
   assign tmo        = (state == ST_WAIT) && !complete && (tcnt == TW'(TIMEOUT - 1));
   assign hold_load  = complete && (dir_q == DIR_RD);
   assign bus_addr   = addr_q + ADDR_W'(offset);
   assign bus_wdata  = bus_wr ? din : wdata_q;

   always_ff @(posedge bus_clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no latch can be inferred.
      state_nx  = state;
      bus_rd    = 1'b0;
      bus_wr    = 1'b0;
      din_ready = 1'b0;
      issue     = 1'b0;
      case (state)
         ST_IDLE:  if (accept && cfg_len != '0) state_nx = ST_ISSUE;
         ST_ISSUE: begin
            if (abort_now) begin
               state_nx = ST_IDLE;
            end else if (bus_ready) begin
               if (dir_q == DIR_RD && hold_space) begin
                  bus_rd   = 1'b1;
                  issue    = 1'b1;
                  state_nx = ST_ACK;
               end else if (dir_q == DIR_WR && din_valid) begin
                  bus_wr    = 1'b1;
                  din_ready = 1'b1;
                  issue     = 1'b1;
                  state_nx  = ST_ACK;
               end
            end
         end
         ST_ACK:   state_nx = ST_WAIT;
         ST_WAIT: begin
            if (complete)  state_nx = (last || abort_now) ? ST_DRAIN : ST_ISSUE;
            else if (tmo)  state_nx = ST_IDLE;
         end
         ST_DRAIN: if (!dout_valid) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge bus_clk) begin
      if (rst) begin
         dir_q   <= DIR_RD;
         addr_q  <= '0;
         len_q   <= '0;
         wrap_q  <= '0;
         offset  <= '0;
         count   <= '0;
         tcnt    <= '0;
         abort_q <= 1'b0;
         wdata_q <= 8'h00;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            dir_q   <= cfg_dir;
            addr_q  <= cfg_addr;
            len_q   <= cfg_len;
            wrap_q  <= cfg_wrap;
            offset  <= '0;
            count   <= '0;
            err     <= 1'b0;
            abort_q <= 1'b0;
            done    <= (cfg_len == '0);
         end else if (busy && abort) begin
            abort_q <= 1'b1;
         end
         if (issue) begin
            tcnt <= '0;
            if (bus_wr) wdata_q <= din;
         end else if (state == ST_ACK || state == ST_WAIT) begin
            tcnt <= tcnt + TW'(1);
         end
         if (complete) begin
            offset <= LEN_W'(wrap_inc(32'(offset), 32'(wrap_q)));
            count  <= count + LEN_W'(1);
         end
         if (tmo) err <= 1'b1;
         // An aborted job drains silently; only a full-length job reports done.
         if (state == ST_DRAIN && !dout_valid) done <= !abort_now;
      end
   end

   sd_dma_hold u_hold (
      .bus_clk    (bus_clk),
      .rst        (rst),
      .load       (hold_load),
      .load_data  (bus_rdata),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

endmodule
